// File: rtl/ef_sram_wb_banked_ctrl_pkg.sv
// Shared types and helpers for the banked Wishbone SRAM controller.
// Per-instance widths are derived from the top's parameters through the helper functions.
package ef_sram_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    RESP
  } state_t;

  localparam int MAX_BANKS  = 8;
  localparam int BANK_IDX_W = 3;

  // Values for the default 32-bit, two-bank configuration.
  localparam int NB = 4;
  localparam int BW = 1;

  typedef logic [BANK_IDX_W-1:0] bank_idx_t;

  function automatic int lanes(input int dw);
    return dw / 8;
  endfunction

  function automatic int bank_bits(input int nbanks);
    return (nbanks > 1) ? $clog2(nbanks) : 0;
  endfunction

endpackage

// File: rtl/ef_sram_wb_banked_ctrl_if.sv
// Wishbone classic slave-side bus bundle for the banked SRAM controller.
interface ef_sram_wb_banked_ctrl_if #(
  parameter int DW = 32
);

  logic            wbs_cyc_i;
  logic            wbs_stb_i;
  logic            wbs_we_i;
  logic [DW/8-1:0] wbs_sel_i;
  logic [31:0]     wbs_adr_i;
  logic [DW-1:0]   wbs_dat_i;
  logic [DW-1:0]   wbs_dat_o;
  logic            wbs_ack_o;
  logic            wbs_err_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_dat_o, wbs_ack_o, wbs_err_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_dat_o, wbs_ack_o, wbs_err_o
  );

endinterface

// File: rtl/ef_sram_bank_rdmux.sv
// NUM_BANKS:1 read-data mux, steered by the bank index registered at request time.
module ef_sram_bank_rdmux
  import ef_sram_pkg::*;
#(
  parameter int DW        = 32,
  parameter int NUM_BANKS = 2
) (
  input  bank_idx_t               bank_sel,
  input  logic [NUM_BANKS*DW-1:0] bank_data,
  output logic [DW-1:0]           rd_data
);

  always_comb begin
    rd_data = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (bank_sel == bank_idx_t'(b)) begin
        rd_data = bank_data[b*DW +: DW];
      end
    end
  end

endmodule

// File: rtl/ef_sram_wb_banked_ctrl.sv
// Wishbone classic slave in front of NUM_BANKS single-port synchronous SRAM macros.
// One transfer at a time: IDLE -> ACCESS -> WAIT (read only) -> RESP -> IDLE.
module ef_sram_wb_banked_ctrl
  import ef_sram_pkg::*;
#(
  parameter int DW        = 32,
  parameter int BANK_AW   = 10,
  parameter int NUM_BANKS = 2,
  parameter int RD_WAIT   = 0
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  ef_sram_wb_banked_ctrl_if.slave wbs,
  output logic [NUM_BANKS-1:0]    sram_en_o,
  output logic [DW/8-1:0]         sram_we_o,
  output logic [BANK_AW-1:0]      sram_addr_o,
  output logic [DW-1:0]           sram_din_o,
  input  logic [NUM_BANKS*DW-1:0] sram_dout_i
);

  localparam int LANES  = lanes(DW);
  localparam int BSEL_W = bank_bits(NUM_BANKS);
  localparam int WORD_W = BANK_AW + BSEL_W;

  state_t               state_q, state_nxt;
  logic [NUM_BANKS-1:0] en_q, en_nxt;
  logic [LANES-1:0]     we_q, we_nxt;
  logic [BANK_AW-1:0]   addr_q, addr_nxt;
  logic [DW-1:0]        din_q, din_nxt;
  bank_idx_t            bank_q, bank_nxt;
  logic                 is_wr_q, is_wr_nxt;
  logic [1:0]           cnt_q, cnt_nxt;
  logic                 ack_q, ack_nxt;
  logic                 err_q, err_nxt;
  logic [DW-1:0]        dat_q, dat_nxt;

  logic [WORD_W-1:0]    req_word;
  logic [31:0]          req_bank_wide;
  bank_idx_t            req_bank;
  logic                 req_valid;
  logic                 req_in_range;
  logic [DW-1:0]        rd_data;
  logic                 unused_adr;

  // Bits above the decoded window are dropped, so the window aliases through the address space.
  assign req_word      = wbs.wbs_adr_i[WORD_W+1:2];
  assign req_bank_wide = 32'(req_word >> BANK_AW);
  assign req_bank      = bank_idx_t'(req_word >> BANK_AW);
  assign req_in_range  = req_bank_wide < 32'(NUM_BANKS);
  assign req_valid     = wbs.wbs_cyc_i && wbs.wbs_stb_i;
  assign unused_adr    = ^{wbs.wbs_adr_i[31:WORD_W+2], wbs.wbs_adr_i[1:0]};

  ef_sram_bank_rdmux #(
    .DW        (DW),
    .NUM_BANKS (NUM_BANKS)
  ) u_rdmux (
    .bank_sel  (bank_q),
    .bank_data (sram_dout_i),
    .rd_data   (rd_data)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      en_q    <= '0;
      we_q    <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      bank_q  <= '0;
      is_wr_q <= 1'b0;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_nxt;
      en_q    <= en_nxt;
      we_q    <= we_nxt;
      addr_q  <= addr_nxt;
      din_q   <= din_nxt;
      bank_q  <= bank_nxt;
      is_wr_q <= is_wr_nxt;
      cnt_q   <= cnt_nxt;
      ack_q   <= ack_nxt;
      err_q   <= err_nxt;
      dat_q   <= dat_nxt;
    end
  end

  // Strobes, ack and err default low so every pulse lasts exactly one cycle.
  always_comb begin
    state_nxt = state_q;
    en_nxt    = '0;
    we_nxt    = '0;
    addr_nxt  = addr_q;
    din_nxt   = din_q;
    bank_nxt  = bank_q;
    is_wr_nxt = is_wr_q;
    cnt_nxt   = cnt_q;
    ack_nxt   = 1'b0;
    err_nxt   = 1'b0;
    dat_nxt   = dat_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (!req_in_range) begin
            err_nxt   = 1'b1;
            state_nxt = RESP;
          end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
              en_nxt[b] = (req_bank == bank_idx_t'(b));
            end
            we_nxt    = wbs.wbs_we_i ? wbs.wbs_sel_i : '0;
            addr_nxt  = req_word[BANK_AW-1:0];
            din_nxt   = wbs.wbs_dat_i;
            bank_nxt  = req_bank;
            is_wr_nxt = wbs.wbs_we_i;
            state_nxt = ACCESS;
          end
        end
      end

      ACCESS: begin
        if (!wbs.wbs_cyc_i) begin
          state_nxt = IDLE;
        end else if (is_wr_q) begin
          ack_nxt   = 1'b1;
          state_nxt = RESP;
        end else begin
          cnt_nxt   = '0;
          state_nxt = WAIT;
        end
      end

      // Macro output is valid from here on; hold off capture for RD_WAIT extra cycles.
      WAIT: begin
        if (!wbs.wbs_cyc_i) begin
          state_nxt = IDLE;
        end else if (cnt_q == 2'(RD_WAIT)) begin
          dat_nxt   = rd_data;
          ack_nxt   = 1'b1;
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt_q + 2'd1;
        end
      end

      RESP: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign sram_en_o     = en_q;
  assign sram_we_o     = we_q;
  assign sram_addr_o   = addr_q;
  assign sram_din_o    = din_q;
  assign wbs.wbs_dat_o = dat_q;
  assign wbs.wbs_ack_o = ack_q;
  assign wbs.wbs_err_o = err_q;

  a_ack_err_excl : assert property (@(posedge wb_clk_i) disable iff (wb_rst_i) !(ack_q && err_q));
  a_en_onehot    : assert property (@(posedge wb_clk_i) disable iff (wb_rst_i) $onehot0(en_q));

endmodule

// File: tb/tb_ef_sram_wb_banked_ctrl.sv
// Directed self-checking bench: three controller instances (2 banks, 3 banks, 2 banks with RD_WAIT=2)
// share one stimulus bus; dut_sel picks which instance's responses are checked.
module tb_ef_sram_wb_banked_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = '0;
  logic [31:0] adr = '0, dat_w = '0;

  always #5 clk = ~clk;

  ef_sram_wb_banked_ctrl_if #(.DW(32)) bus_a ();
  ef_sram_wb_banked_ctrl_if #(.DW(32)) bus_b ();
  ef_sram_wb_banked_ctrl_if #(.DW(32)) bus_c ();

  assign bus_a.wbs_cyc_i = cyc; assign bus_a.wbs_stb_i = stb; assign bus_a.wbs_we_i = we;
  assign bus_a.wbs_sel_i = sel; assign bus_a.wbs_adr_i = adr; assign bus_a.wbs_dat_i = dat_w;
  assign bus_b.wbs_cyc_i = cyc; assign bus_b.wbs_stb_i = stb; assign bus_b.wbs_we_i = we;
  assign bus_b.wbs_sel_i = sel; assign bus_b.wbs_adr_i = adr; assign bus_b.wbs_dat_i = dat_w;
  assign bus_c.wbs_cyc_i = cyc; assign bus_c.wbs_stb_i = stb; assign bus_c.wbs_we_i = we;
  assign bus_c.wbs_sel_i = sel; assign bus_c.wbs_adr_i = adr; assign bus_c.wbs_dat_i = dat_w;

  logic [1:0] en_a, en_c;
  logic [2:0] en_b;
  logic [3:0] we_a, we_b, we_c;
  logic [9:0] addr_a, addr_b, addr_c;
  logic [31:0] din_a, din_b, din_c;
  logic [63:0] dout_a, dout_c;
  logic [95:0] dout_b;

  ef_sram_wb_banked_ctrl #(.DW(32), .BANK_AW(10), .NUM_BANKS(2), .RD_WAIT(0)) dut_a (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs(bus_a), .sram_en_o(en_a), .sram_we_o(we_a),
    .sram_addr_o(addr_a), .sram_din_o(din_a), .sram_dout_i(dout_a));

  ef_sram_wb_banked_ctrl #(.DW(32), .BANK_AW(10), .NUM_BANKS(3), .RD_WAIT(0)) dut_b (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs(bus_b), .sram_en_o(en_b), .sram_we_o(we_b),
    .sram_addr_o(addr_b), .sram_din_o(din_b), .sram_dout_i(dout_b));

  ef_sram_wb_banked_ctrl #(.DW(32), .BANK_AW(10), .NUM_BANKS(2), .RD_WAIT(2)) dut_c (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs(bus_c), .sram_en_o(en_c), .sram_we_o(we_c),
    .sram_addr_o(addr_c), .sram_din_o(din_c), .sram_dout_i(dout_c));

  // Single-port macro models: 1-cycle read latency, byte-lane writes, read returns old data.
  logic [31:0] mem_a [2][1024];
  logic [31:0] mem_b [3][1024];
  logic [31:0] mem_c [2][1024];

  always @(posedge clk) begin
    for (int b = 0; b < 2; b++) begin
      if (en_a[b]) begin
        for (int k = 0; k < 4; k++) if (we_a[k]) mem_a[b][addr_a][8*k +: 8] <= din_a[8*k +: 8];
        dout_a[b*32 +: 32] <= mem_a[b][addr_a];
      end
    end
  end

  always @(posedge clk) begin
    for (int b = 0; b < 3; b++) begin
      if (en_b[b]) begin
        for (int k = 0; k < 4; k++) if (we_b[k]) mem_b[b][addr_b][8*k +: 8] <= din_b[8*k +: 8];
        dout_b[b*32 +: 32] <= mem_b[b][addr_b];
      end
    end
  end

  always @(posedge clk) begin
    for (int b = 0; b < 2; b++) begin
      if (en_c[b]) begin
        for (int k = 0; k < 4; k++) if (we_c[k]) mem_c[b][addr_c][8*k +: 8] <= din_c[8*k +: 8];
        dout_c[b*32 +: 32] <= mem_c[b][addr_c];
      end
    end
  end

  int          dut_sel = 0;
  logic        obs_ack, obs_err;
  logic [31:0] obs_dat;
  logic [2:0]  obs_en;
  logic [3:0]  obs_we;
  logic [9:0]  obs_addr;

  always_comb begin
    obs_ack  = bus_a.wbs_ack_o;
    obs_err  = bus_a.wbs_err_o;
    obs_dat  = bus_a.wbs_dat_o;
    obs_en   = {1'b0, en_a};
    obs_we   = we_a;
    obs_addr = addr_a;
    if (dut_sel == 1) begin
      obs_ack = bus_b.wbs_ack_o; obs_err = bus_b.wbs_err_o; obs_dat = bus_b.wbs_dat_o;
      obs_en  = en_b;            obs_we  = we_b;            obs_addr = addr_b;
    end else if (dut_sel == 2) begin
      obs_ack = bus_c.wbs_ack_o; obs_err = bus_c.wbs_err_o; obs_dat = bus_c.wbs_dat_o;
      obs_en  = {1'b0, en_c};    obs_we  = we_c;            obs_addr = addr_c;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Results of the last applyStimulus transfer; lat is the edge index (0 = sampling edge) of ack/err.
  int          t_lat;
  logic        t_ack, t_err;
  logic [31:0] t_dat;
  logic [2:0]  t_en0;
  logic [3:0]  t_we0;
  logic [9:0]  t_addr0;

  task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [3:0] s,
                               input logic [31:0] d);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat_w = d;
    t_lat = -1; t_ack = 1'b0; t_err = 1'b0; t_dat = '0; t_en0 = '0; t_we0 = '0; t_addr0 = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 0) begin
        t_en0 = obs_en; t_we0 = obs_we; t_addr0 = obs_addr;
      end
      if (obs_ack || obs_err) begin
        t_lat = i; t_ack = obs_ack; t_err = obs_err; t_dat = obs_dat;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  logic [31:0] b2b_adr [4];
  logic [31:0] b2b_dat [4];
  int          idx, ack_cnt, en_cnt, multi_en, en_bad, gap_bad, both, last_ack, abort_acks;

  initial begin
    b2b_adr[0] = 32'h0000_0008; b2b_adr[1] = 32'h0000_1008;
    b2b_adr[2] = 32'h0000_000C; b2b_adr[3] = 32'h0000_100C;
    b2b_dat[0] = 32'hA000_0001; b2b_dat[1] = 32'hA000_0002;
    b2b_dat[2] = 32'hA000_0003; b2b_dat[3] = 32'hA000_0004;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_ack",  32'(obs_ack),  32'h0);
    checkOutput("rst_err",  32'(obs_err),  32'h0);
    checkOutput("rst_dat",  obs_dat,       32'h0);
    checkOutput("rst_en",   32'(obs_en),   32'h0);
    checkOutput("rst_we",   32'(obs_we),   32'h0);
    checkOutput("rst_addr", 32'(obs_addr), 32'h0);

    // Single write, cycle by cycle: strobe one cycle after E0, ack after E1.
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h0000_1004; sel = 4'hF; dat_w = 32'hDEAD_BEEF;
    @(negedge clk);
    checkOutput("wr_en_e0",   32'(obs_en),   32'h2);
    checkOutput("wr_we_e0",   32'(obs_we),   32'hF);
    checkOutput("wr_addr_e0", 32'(obs_addr), 32'h1);
    checkOutput("wr_din_e0",  din_a,         32'hDEAD_BEEF);
    checkOutput("wr_ack_e0",  32'(obs_ack),  32'h0);
    @(negedge clk);
    checkOutput("wr_en_e1",   32'(obs_en),   32'h0);
    checkOutput("wr_we_e1",   32'(obs_we),   32'h0);
    checkOutput("wr_ack_e1",  32'(obs_ack),  32'h1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
    checkOutput("wr_ack_e2",  32'(obs_ack),  32'h0);
    repeat (4) @(negedge clk);

    applyStimulus(1'b0, 32'h0000_1004, 4'h0, 32'h0);
    checkOutput("rd_lat", 32'(t_lat), 32'd2);
    checkOutput("rd_dat", t_dat,      32'hDEAD_BEEF);
    checkOutput("rd_en0", 32'(t_en0), 32'h2);
    checkOutput("rd_we0", 32'(t_we0), 32'h0);

    // Asynchronous reset in the middle of a read.
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h0000_1004;
    @(negedge clk);
    checkOutput("mr_en_pre", 32'(obs_en), 32'h2);
    #2 rst = 1'b1;
    #1;
    checkOutput("mr_en",  32'(obs_en),  32'h0);
    checkOutput("mr_ack", 32'(obs_ack), 32'h0);
    checkOutput("mr_err", 32'(obs_err), 32'h0);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("mr_post_dat",  obs_dat,       32'h0);
    checkOutput("mr_post_addr", 32'(obs_addr), 32'h0);
    checkOutput("mr_post_ack",  32'(obs_ack),  32'h0);
    repeat (3) @(negedge clk);

    // Byte lanes and sel = 0 writes.
    applyStimulus(1'b1, 32'h0000_0010, 4'hF, 32'hFFFF_FFFF);
    checkOutput("bl_full_lat", 32'(t_lat), 32'd1);
    applyStimulus(1'b1, 32'h0000_0010, 4'b0101, 32'h1122_3344);
    checkOutput("bl_part_we0", 32'(t_we0), 32'h5);
    applyStimulus(1'b0, 32'h0000_0010, 4'h0, 32'h0);
    checkOutput("bl_rd_dat", t_dat, 32'hFF22_FF44);
    applyStimulus(1'b1, 32'h0000_0010, 4'h0, 32'h0000_0000);
    checkOutput("bl_sel0_lat",  32'(t_lat), 32'd1);
    checkOutput("bl_sel0_ack",  32'(t_ack), 32'h1);
    checkOutput("bl_sel0_en0",  32'(t_en0), 32'h1);
    checkOutput("bl_sel0_we0",  32'(t_we0), 32'h0);
    checkOutput("bl_hold_dat",  t_dat,      32'hFF22_FF44);
    applyStimulus(1'b0, 32'h0000_0010, 4'hF, 32'h0);
    checkOutput("bl_sel0_rd", t_dat, 32'hFF22_FF44);
    applyStimulus(1'b0, 32'h4000_2010, 4'hF, 32'h0);
    checkOutput("alias_rd", t_dat, 32'hFF22_FF44);

    // Three-bank instance: last word of bank 2, then out-of-range bank 3.
    dut_sel = 1;
    applyStimulus(1'b1, 32'h0000_2FFC, 4'hF, 32'h1234_5678);
    checkOutput("rg_wr_lat", 32'(t_lat),   32'd1);
    checkOutput("rg_en0",    32'(t_en0),   32'h4);
    checkOutput("rg_addr0",  32'(t_addr0), 32'h3FF);
    applyStimulus(1'b0, 32'h0000_2FFC, 4'hF, 32'h0);
    checkOutput("rg_rd_lat", 32'(t_lat), 32'd2);
    checkOutput("rg_rd_dat", t_dat,      32'h1234_5678);
    applyStimulus(1'b0, 32'h0000_3000, 4'hF, 32'h0);
    checkOutput("rg_err",     32'(t_err), 32'h1);
    checkOutput("rg_err_ack", 32'(t_ack), 32'h0);
    checkOutput("rg_err_lat", 32'(t_lat), 32'd0);
    checkOutput("rg_err_en0", 32'(t_en0), 32'h0);

    // Read wait states and abort during WAIT.
    dut_sel = 2;
    applyStimulus(1'b1, 32'h0000_0020, 4'hF, 32'hCAFE_F00D);
    checkOutput("rw_wr_lat", 32'(t_lat), 32'd1);
    applyStimulus(1'b0, 32'h0000_0020, 4'hF, 32'h0);
    checkOutput("rw_rd_lat", 32'(t_lat), 32'd4);
    checkOutput("rw_rd_dat", t_dat,      32'hCAFE_F00D);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h0000_0020;
    repeat (2) @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    abort_acks = 0;
    repeat (8) begin
      @(negedge clk);
      if (obs_ack || obs_err) abort_acks++;
    end
    checkOutput("ab_no_ack", 32'(abort_acks), 32'd0);
    applyStimulus(1'b0, 32'h0000_1004, 4'hF, 32'h0);
    checkOutput("ab_next_lat", 32'(t_lat), 32'd4);
    checkOutput("ab_next_dat", t_dat,      32'hDEAD_BEEF);

    // Back-to-back writes with stb held, alternating banks.
    dut_sel = 0;
    idx = 0; ack_cnt = 0; en_cnt = 0; multi_en = 0; en_bad = 0; gap_bad = 0; both = 0; last_ack = -1;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = b2b_adr[0]; dat_w = b2b_dat[0];
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (obs_en != 3'b000) begin
        en_cnt++;
        if ($countones(obs_en) != 1) multi_en++;
        if (obs_en != (((idx % 2) == 0) ? 3'b001 : 3'b010)) en_bad++;
      end
      if (obs_ack && obs_err) both++;
      if (obs_ack) begin
        if (ack_cnt > 0 && (c - last_ack) != 3) gap_bad++;
        last_ack = c;
        ack_cnt++;
        idx++;
        if (idx < 4) begin
          adr = b2b_adr[idx]; dat_w = b2b_dat[idx];
        end else begin
          cyc = 1'b0; stb = 1'b0; we = 1'b0;
        end
      end
    end
    checkOutput("b2b_acks",   32'(ack_cnt),  32'd4);
    checkOutput("b2b_ens",    32'(en_cnt),   32'd4);
    checkOutput("b2b_multi",  32'(multi_en), 32'd0);
    checkOutput("b2b_bank",   32'(en_bad),   32'd0);
    checkOutput("b2b_gap",    32'(gap_bad),  32'd0);
    checkOutput("b2b_excl",   32'(both),     32'd0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, b2b_adr[i], 4'hF, 32'h0);
      checkOutput($sformatf("b2b_rd%0d", i), t_dat, b2b_dat[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
